// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator (I/S/B/U/J/Z) behind a registered valid/ready stage.
// Latency 1 cycle; SKID=1 adds a skid entry so in_ready is a flop, SKID=0 stalls combinationally.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5,
   parameter bit SKID  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_immSrc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             illegal;
   } ent_t;

   // Bit 1 of the encoding is the skid-valid flop that drives in_ready directly.
   typedef enum logic [1:0] {
      st_empty = 2'b00,
      st_one   = 2'b01,
      st_full  = 2'b10
   } state_t;

   state_t      state_q, state_d;
   ent_t        new_ent, out_q, sk_q;
   logic [31:0] imm32;
   logic        is_z;
   logic        accept, deliver;
   logic        load_out, load_sk, pop_sk;
   logic        unused_opcode;

   assign unused_opcode = ^in_instr[6:0];

   always_comb begin
      imm32 = '0;
      is_z  = 1'b0;
      new_ent.illegal = 1'b0;
      case (in_immSrc)
         3'b000: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         3'b001: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         3'b010: imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
         3'b011: imm32 = {in_instr[31:12], 12'b0};
         3'b100: imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
         3'b101: is_z  = 1'b1;
         default: new_ent.illegal = 1'b1;
      endcase
      // U-type sign-extends from bit 31 on RV64, matching lui semantics.
      new_ent.imm = is_z ? {{(XLEN-5){1'b0}}, in_instr[19:15]}
                         : {{(XLEN-31){imm32[31]}}, imm32[30:0]};
      new_ent.tag = in_tag;
   end

   assign out_valid = (state_q != st_empty);
   assign in_ready  = SKID ? ~state_q[1] : ((state_q == st_empty) | out_ready);
   assign accept    = in_valid & in_ready;
   assign deliver   = out_valid & out_ready;

   always_comb begin
      state_d  = state_q;
      load_out = 1'b0;
      load_sk  = 1'b0;
      pop_sk   = 1'b0;
      case (state_q)
         st_empty: begin
            if (accept) begin
               state_d  = st_one;
               load_out = 1'b1;
            end
         end
         st_one: begin
            if (deliver && accept) begin
               load_out = 1'b1;
            end else if (deliver) begin
               state_d = st_empty;
            end else if (accept) begin
               state_d = st_full;
               load_sk = 1'b1;
            end
         end
         st_full: begin
            if (deliver) begin
               state_d = st_one;
               pop_sk  = 1'b1;
            end
         end
         default: state_d = st_empty;
      endcase
      // Flush wins over any same-cycle accept or deliver; upstream replays.
      if (flush) begin
         state_d  = st_empty;
         load_out = 1'b0;
         load_sk  = 1'b0;
         pop_sk   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= st_empty;
         out_q   <= '0;
         sk_q    <= '0;
      end else begin
         state_q <= state_d;
         if (load_out) begin
            out_q <= new_ent;
         end else if (pop_sk) begin
            out_q <= sk_q;
         end
         if (load_sk) begin
            sk_q <= new_ent;
         end
      end
   end

   assign out_imm     = out_q.imm;
   assign out_tag     = out_q.tag;
   assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: three instances (XLEN32/SKID1, XLEN64/SKID1, XLEN32/SKID0) on shared stimulus.
module tb_imm_gen_pipe;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [2:0]  in_immSrc;
   logic [4:0]  in_tag;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_out_illegal;
   logic [31:0] a_out_imm;
   logic [4:0]  a_out_tag;
   logic        b_in_ready, b_out_valid, b_out_illegal;
   logic [63:0] b_out_imm;
   logic [4:0]  b_out_tag;
   logic        c_in_ready, c_out_valid, c_out_illegal;
   logic [31:0] c_out_imm;
   logic [4:0]  c_out_tag;

   int checks = 0;
   int errors = 0;

   imm_gen_pipe #(.XLEN(32), .TAG_W(5), .SKID(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
      .in_immSrc(in_immSrc), .in_tag(in_tag),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
      .out_tag(a_out_tag), .out_illegal(a_out_illegal)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(5), .SKID(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
      .in_immSrc(in_immSrc), .in_tag(in_tag),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
      .out_tag(b_out_tag), .out_illegal(b_out_illegal)
   );

   imm_gen_pipe #(.XLEN(32), .TAG_W(5), .SKID(1'b0)) dut_c (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(c_in_ready), .in_instr(in_instr),
      .in_immSrc(in_immSrc), .in_tag(in_tag),
      .out_valid(c_out_valid), .out_ready(out_ready), .out_imm(c_out_imm),
      .out_tag(c_out_tag), .out_illegal(c_out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tg);
      in_valid  = v;
      in_instr  = ins;
      in_immSrc = src;
      in_tag    = tg;
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 32'h0, 3'b000, 5'd0);
      #3;
      chk("rst_a_valid", a_out_valid, 1'b0);
      chk("rst_a_imm", a_out_imm, 32'h0);
      chk("rst_a_tag", a_out_tag, 5'd0);
      chk("rst_a_ill", a_out_illegal, 1'b0);
      chk("rst_a_rdy", a_in_ready, 1'b1);
      chk("rst_c_rdy", c_in_ready, 1'b1);
      #9 rst_n = 1'b1;

      // Decode patterns, back-to-back with out_ready high.
      drive(1'b1, 32'hFFF00093, 3'b000, 5'd3);
      tick();
      chk("i_valid", a_out_valid, 1'b1);
      chk("i_imm32", a_out_imm, 32'hFFFFFFFF);
      chk("i_imm64", b_out_imm, 64'hFFFFFFFFFFFFFFFF);
      chk("i_ill", a_out_illegal, 1'b0);
      chk("i_tag", a_out_tag, 5'd3);
      drive(1'b1, 32'hFE000EE3, 3'b010, 5'd4);
      tick();
      chk("b_imm", a_out_imm, 32'hFFFFFFFC);
      drive(1'b1, 32'hFF9FF06F, 3'b100, 5'd5);
      tick();
      chk("j_imm", a_out_imm, 32'hFFFFFFF8);
      chk("j_imm64", b_out_imm, 64'hFFFFFFFFFFFFFFF8);
      drive(1'b1, 32'h800F8000, 3'b101, 5'd6);
      tick();
      chk("z_imm", a_out_imm, 32'h0000001F);
      chk("z_imm64", b_out_imm, 64'h000000000000001F);
      drive(1'b1, 32'h80000000, 3'b001, 5'd7);
      tick();
      chk("s_imm", a_out_imm, 32'hFFFFF800);
      drive(1'b1, 32'h7FF00000, 3'b000, 5'd8);
      tick();
      chk("i_pos_imm", a_out_imm, 32'h000007FF);
      drive(1'b1, 32'h800000B7, 3'b011, 5'd9);
      tick();
      chk("u_imm32", a_out_imm, 32'h80000000);
      chk("u_imm64", b_out_imm, 64'hFFFFFFFF80000000);
      drive(1'b1, 32'hFFFFFFFF, 3'b111, 5'd10);
      tick();
      chk("ill_imm64", b_out_imm, 64'h0);
      chk("ill_flag", b_out_illegal, 1'b1);
      chk("ill_tag", b_out_tag, 5'd10);
      drive(1'b1, 32'h12345037, 3'b011, 5'd11);
      tick();
      chk("u_small", a_out_imm, 32'h12345000);
      chk("ill_clear", a_out_illegal, 1'b0);
      drive(1'b0, 32'h0, 3'b000, 5'd0);
      tick();
      chk("drain_valid", a_out_valid, 1'b0);

      // Skid fill under backpressure, then ordered drain.
      out_ready = 1'b0;
      drive(1'b1, 32'h00100093, 3'b000, 5'd1);
      tick();
      chk("sk1_rdy", a_in_ready, 1'b1);
      chk("sk1_tag", a_out_tag, 5'd1);
      chk("c_stall_rdy", c_in_ready, 1'b0);
      drive(1'b1, 32'h00200093, 3'b000, 5'd2);
      tick();
      chk("sk2_rdy", a_in_ready, 1'b0);
      chk("sk2_tag", a_out_tag, 5'd1);
      chk("c_hold_tag", c_out_tag, 5'd1);
      chk("c_hold_imm", c_out_imm, 32'h00000001);
      drive(1'b1, 32'h00300093, 3'b000, 5'd3);
      tick();
      chk("sk3_rdy", a_in_ready, 1'b0);
      chk("sk3_hold_tag", a_out_tag, 5'd1);
      chk("sk3_hold_imm", a_out_imm, 32'h00000001);
      out_ready = 1'b1;
      #1;
      chk("dr1_tag", a_out_tag, 5'd1);
      chk("dr1_rdy", a_in_ready, 1'b0);
      tick();
      chk("dr2_valid", a_out_valid, 1'b1);
      chk("dr2_tag", a_out_tag, 5'd2);
      chk("dr2_rdy", a_in_ready, 1'b1);
      tick();
      chk("dr3_tag", a_out_tag, 5'd3);
      chk("dr3_imm", a_out_imm, 32'h00000003);
      drive(1'b0, 32'h0, 3'b000, 5'd0);
      tick();
      chk("dr_empty", a_out_valid, 1'b0);

      // Flush from FULL with a same-cycle valid input.
      out_ready = 1'b0;
      drive(1'b1, 32'h00400093, 3'b000, 5'd4);
      tick();
      drive(1'b1, 32'h00500093, 3'b000, 5'd5);
      tick();
      chk("fl_full_rdy", a_in_ready, 1'b0);
      chk("fl_c_valid", c_out_valid, 1'b1);
      flush = 1'b1;
      drive(1'b1, 32'h00600093, 3'b000, 5'd6);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 3'b000, 5'd0);
      chk("fl_a_valid", a_out_valid, 1'b0);
      chk("fl_a_rdy", a_in_ready, 1'b1);
      chk("fl_c_valid0", c_out_valid, 1'b0);
      chk("fl_c_rdy", c_in_ready, 1'b1);
      out_ready = 1'b1;
      tick();
      chk("fl_a_none", a_out_valid, 1'b0);
      chk("fl_c_none", c_out_valid, 1'b0);

      // Asynchronous reset mid-burst.
      drive(1'b1, 32'h00700093, 3'b000, 5'd7);
      tick();
      chk("ar_pre_valid", a_out_valid, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_a_valid", a_out_valid, 1'b0);
      chk("ar_c_valid", c_out_valid, 1'b0);
      chk("ar_a_imm", a_out_imm, 32'h0);
      chk("ar_a_tag", a_out_tag, 5'd0);
      chk("ar_a_rdy", a_in_ready, 1'b1);
      #2 rst_n = 1'b1;
      drive(1'b1, 32'h00900093, 3'b000, 5'd9);
      #1;
      chk("ar_rel_valid", a_out_valid, 1'b0);
      tick();
      chk("ar_first_valid", a_out_valid, 1'b1);
      chk("ar_first_tag", a_out_tag, 5'd9);
      chk("ar_first_c_tag", c_out_tag, 5'd9);
      drive(1'b0, 32'h0, 3'b000, 5'd0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
